// File: rtl/nis_cpu_uart_cpu_cpu_mul_combine.sv
// nis_cpu_uart_cpu_cpu_mul_combine
//
// Assembles multiply results from the three registered 16x16 partial
// products produced by the CPU multiplier cell (lo*lo, lo*hi, hi*lo).
//   MUL            : low 32 bits, one-cycle latency, no stall.
//   MULXUU/SU/SS   : high 32 bits. The missing hi*hi product is built by a
//                    16-iteration shift-add engine, then the signed
//                    corrections are applied. The pipeline is stalled for
//                    17 cycles and the result appears 18 cycles after accept.
//
// Ports
//   clk            CPU clock, all state on the rising edge
//   reset_n        asynchronous active-low reset
//   M_en           M-stage advance enable
//   M_valid        multiply instruction present in M stage
//   M_op           0=MUL 1=MULXUU 2=MULXSU 3=MULXSS
//   M_src1/M_src2  operands A and B
//   M_mul_cell_p1  A[15:0]*B[15:0]
//   M_mul_cell_p2  A[15:0]*B[31:16]
//   M_mul_cell_p3  A[31:16]*B[15:0]
//   W_mul_result   result, holds last value between strobes
//   W_mul_valid    one-cycle result strobe
//   M_mul_stall    engine busy (decoded from registered state only)

module nis_cpu_uart_cpu_cpu_mul_combine #(
  parameter int MULX_ITER = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        M_en,
  input  logic        M_valid,
  input  logic [1:0]  M_op,
  input  logic [31:0] M_src1,
  input  logic [31:0] M_src2,
  input  logic [31:0] M_mul_cell_p1,
  input  logic [31:0] M_mul_cell_p2,
  input  logic [31:0] M_mul_cell_p3,
  output logic [31:0] W_mul_result,
  output logic        W_mul_valid,
  output logic        M_mul_stall
);

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULXSU = 2'd2;
  localparam logic [1:0] OP_MULXSS = 2'd3;

  localparam logic [3:0] CNT_LAST = 4'(MULX_ITER - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HH   = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [33:0] r_mid;
  logic [1:0]  r_op;
  logic [31:0] r_acc;
  logic [3:0]  r_cnt;
  logic [31:0] r_result;
  logic        r_valid;

  logic        w_accept;
  logic [33:0] w_mid;
  logic [31:0] w_low;
  logic [15:0] w_b_hi;
  logic [31:0] w_addend;
  logic [31:0] w_uhi;
  logic [31:0] w_corr_a;
  logic [31:0] w_corr_b;
  logic [31:0] w_fin;

  // ---------------------------------------------------------------------
  // Accept and low-half assembly
  // ---------------------------------------------------------------------
  assign w_accept = M_valid & M_en & (r_state == ST_IDLE);

  // Middle column sum; 34 bits so the carries into the high half survive.
  assign w_mid = {2'b00, M_mul_cell_p2} + {2'b00, M_mul_cell_p3}
               + {18'd0, M_mul_cell_p1[31:16]};
  assign w_low = {w_mid[15:0], M_mul_cell_p1[15:0]};

  // ---------------------------------------------------------------------
  // hi*hi shift-add step: bit r_cnt of B[31:16] selects A[31:16] << r_cnt
  // ---------------------------------------------------------------------
  assign w_b_hi   = r_b[31:16];
  assign w_addend = w_b_hi[r_cnt] ? ({16'd0, r_a[31:16]} << r_cnt) : 32'd0;

  // ---------------------------------------------------------------------
  // High-half finish: unsigned high word, then two's-complement fixups.
  // A signed operand with its sign bit set contributes -2^32 * other
  // operand, which subtracts the other operand from the high word.
  // ---------------------------------------------------------------------
  assign w_uhi    = r_acc + {14'd0, r_mid[33:16]};
  assign w_corr_a = (((r_op == OP_MULXSU) || (r_op == OP_MULXSS)) && r_a[31])
                    ? r_b : 32'd0;
  assign w_corr_b = ((r_op == OP_MULXSS) && r_b[31]) ? r_a : 32'd0;
  assign w_fin    = w_uhi - w_corr_a - w_corr_b;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (M_op != OP_MUL)) begin
          w_state_next = ST_HH;
        end
      end
      ST_HH: begin
        if (r_cnt == CNT_LAST) begin
          w_state_next = ST_FIN;
        end
      end
      ST_FIN: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs (stall is a pure decode of the registered state)
  // ---------------------------------------------------------------------
  always_comb begin
    M_mul_stall = (r_state != ST_IDLE);
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_mid    <= 34'd0;
      r_op     <= 2'd0;
      r_acc    <= 32'd0;
      r_cnt    <= 4'd0;
      r_result <= 32'd0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (M_op == OP_MUL) begin
              r_result <= w_low;
              r_valid  <= 1'b1;
            end else begin
              r_a   <= M_src1;
              r_b   <= M_src2;
              r_mid <= w_mid;
              r_op  <= M_op;
              r_acc <= 32'd0;
              r_cnt <= 4'd0;
            end
          end
        end
        ST_HH: begin
          r_acc <= r_acc + w_addend;
          r_cnt <= r_cnt + 4'd1;
        end
        ST_FIN: begin
          r_result <= w_fin;
          r_valid  <= 1'b1;
          r_cnt    <= 4'd0;
        end
        default: begin
          r_cnt <= 4'd0;
        end
      endcase
    end
  end

  assign W_mul_result = r_result;
  assign W_mul_valid  = r_valid;

endmodule

// File: tb/tb_nis_cpu_uart_cpu_cpu_mul_combine.sv
module tb_nis_cpu_uart_cpu_cpu_mul_combine;

  logic        clk;
  logic        reset_n;
  logic        M_en;
  logic        M_valid;
  logic [1:0]  M_op;
  logic [31:0] M_src1;
  logic [31:0] M_src2;
  logic [31:0] M_mul_cell_p1;
  logic [31:0] M_mul_cell_p2;
  logic [31:0] M_mul_cell_p3;
  logic [31:0] W_mul_result;
  logic        W_mul_valid;
  logic        M_mul_stall;

  int pass_cnt  = 0;
  int total_cnt = 0;

  nis_cpu_uart_cpu_cpu_mul_combine #(.MULX_ITER(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .M_en          (M_en),
    .M_valid       (M_valid),
    .M_op          (M_op),
    .M_src1        (M_src1),
    .M_src2        (M_src2),
    .M_mul_cell_p1 (M_mul_cell_p1),
    .M_mul_cell_p2 (M_mul_cell_p2),
    .M_mul_cell_p3 (M_mul_cell_p3),
    .W_mul_result  (W_mul_result),
    .W_mul_valid   (W_mul_valid),
    .M_mul_stall   (M_mul_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full 64-bit product in plain arithmetic, pick the half.
  function automatic logic [31:0] ref_mul(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, prod;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    ua = $signed({32'd0, a});
    ub = $signed({32'd0, b});
    case (op)
      2'd0:    prod = ua * ub;
      2'd1:    prod = ua * ub;
      2'd2:    prod = sa * ub;
      default: prod = sa * sb;
    endcase
    return (op == 2'd0) ? prod[31:0] : prod[63:32];
  endfunction

  // Drives operands plus the partial products the multiplier cell would give.
  task automatic set_inputs(input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b);
    M_op          = op;
    M_src1        = a;
    M_src2        = b;
    M_mul_cell_p1 = 32'(a[15:0]) * 32'(b[15:0]);
    M_mul_cell_p2 = 32'(a[15:0]) * 32'(b[31:16]);
    M_mul_cell_p3 = 32'(a[31:16]) * 32'(b[15:0]);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    M_en = 1'b0; M_valid = 1'b0;
    set_inputs(2'd0, 32'd0, 32'd0);
    #2;
    total_cnt++;
    if (W_mul_valid !== 1'b0 || M_mul_stall !== 1'b0 || W_mul_result !== 32'd0) begin
      $display("FAIL reset_state valid=%b stall=%b result=%h required 0/0/00000000",
               W_mul_valid, M_mul_stall, W_mul_result);
    end else pass_cnt++;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (W_mul_valid !== 1'b0 || M_mul_stall !== 1'b0 || W_mul_result !== 32'd0) begin
      $display("FAIL post_reset_idle valid=%b stall=%b result=%h required 0/0/00000000",
               W_mul_valid, M_mul_stall, W_mul_result);
    end else pass_cnt++;
    $display("reset: done");
  endtask

  // Single MUL: strobe at the first negedge after the accept edge.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input string name);
    logic [31:0] exp;
    exp = ref_mul(2'd0, a, b);
    @(negedge clk);
    set_inputs(2'd0, a, b);
    M_valid = 1'b1; M_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    M_valid = 1'b0;
    total_cnt++;
    if (W_mul_valid !== 1'b1 || W_mul_result !== exp || M_mul_stall !== 1'b0) begin
      $display("FAIL %s got valid=%b result=%h stall=%b required 1/%h/0",
               name, W_mul_valid, W_mul_result, M_mul_stall, exp);
    end else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (W_mul_valid !== 1'b0 || W_mul_result !== exp) begin
      $display("FAIL %s_hold got valid=%b result=%h required 0/%h",
               name, W_mul_valid, W_mul_result, exp);
    end else pass_cnt++;
    $display("MUL %h x %h -> %h (%s)", a, b, W_mul_result, name);
  endtask

  task automatic test_mul();
    do_mul(32'h12345678, 32'h00000010, "mul_directed");
    for (int i = 0; i < 4; i++) do_mul($urandom, $urandom, "mul_random");
  endtask

  // MULX: strobe at the 18th negedge after accept, stall seen 17 times.
  // Operands and partials are scrambled during the stall to show they are
  // only sampled on accept.
  task automatic do_mulx(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input string name);
    logic [31:0] exp;
    int stall_n, valid_at, strobes;
    logic [31:0] got;
    exp = ref_mul(op, a, b);
    stall_n = 0; valid_at = -1; strobes = 0; got = 32'd0;
    @(negedge clk);
    set_inputs(op, a, b);
    M_valid = 1'b1; M_en = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        M_valid = 1'b0; M_en = 1'b0;
        set_inputs($urandom_range(0, 3), $urandom, $urandom);
      end
      if (M_mul_stall) stall_n++;
      if (W_mul_valid) begin
        strobes++;
        if (valid_at < 0) begin
          valid_at = n;
          got = W_mul_result;
        end
      end
    end
    total_cnt++;
    if (got !== exp) begin
      $display("FAIL %s_result got %h required %h", name, got, exp);
    end else pass_cnt++;
    total_cnt++;
    if (valid_at != 18 || strobes != 1) begin
      $display("FAIL %s_latency got valid at %0d (%0d strobes) required 18 (1 strobe)",
               name, valid_at, strobes);
    end else pass_cnt++;
    total_cnt++;
    if (stall_n != 17) begin
      $display("FAIL %s_stall got %0d stall cycles required 17", name, stall_n);
    end else pass_cnt++;
    $display("MULX op=%0d %h x %h -> %h lat=%0d stall=%0d (%s)",
             op, a, b, got, valid_at, stall_n, name);
  endtask

  task automatic test_mulx();
    do_mulx(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulxuu_ones");
    do_mulx(2'd1, 32'h00010000, 32'h00010000, "mulxuu_pow");
    do_mulx(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulxss_neg1");
    do_mulx(2'd3, 32'h80000000, 32'h80000000, "mulxss_min");
    do_mulx(2'd3, 32'h80000000, 32'h00000002, "mulxss_mix");
    do_mulx(2'd2, 32'hFFFFFFFF, 32'h00000002, "mulxsu_neg");
    do_mulx(2'd2, 32'h00000002, 32'hFFFFFFFF, "mulxsu_pos");
    for (int i = 0; i < 6; i++)
      do_mulx(2'($urandom_range(1, 3)), $urandom, $urandom, "mulx_random");
  endtask

  // MUL every cycle: one strobe per cycle, each with its own product.
  task automatic test_back_to_back();
    logic [31:0] a_q[$], b_q[$];
    logic [31:0] a, b, exp;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp = ref_mul(2'd0, a_q[0], b_q[0]);
        void'(a_q.pop_front()); void'(b_q.pop_front());
        total_cnt++;
        if (W_mul_valid !== 1'b1 || W_mul_result !== exp || M_mul_stall !== 1'b0) begin
          $display("FAIL b2b_%0d got valid=%b result=%h stall=%b required 1/%h/0",
                   i, W_mul_valid, W_mul_result, M_mul_stall, exp);
        end else pass_cnt++;
        $display("B2B MUL %0d -> %h", i - 1, W_mul_result);
      end
      if (i < 5) begin
        a = $urandom; b = $urandom;
        a_q.push_back(a); b_q.push_back(b);
        set_inputs(2'd0, a, b);
        M_valid = 1'b1; M_en = 1'b1;
      end else begin
        M_valid = 1'b0;
      end
    end
  endtask

  // M_valid and M_en held high across a MULX; then MUL on edge k+18.
  task automatic test_hold_valid();
    logic [31:0] a, b, exp, ma, mb;
    int strobes, valid_at;
    a = $urandom; b = $urandom;
    ma = $urandom; mb = $urandom;
    exp = ref_mul(2'd3, a, b);
    strobes = 0; valid_at = -1;
    @(negedge clk);
    set_inputs(2'd3, a, b);
    M_valid = 1'b1; M_en = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      if (W_mul_valid) begin
        strobes++;
        valid_at = n;
        total_cnt++;
        if (W_mul_result !== exp) begin
          $display("FAIL hold_mulx_result got %h required %h", W_mul_result, exp);
        end else pass_cnt++;
      end
    end
    total_cnt++;
    if (strobes != 1 || valid_at != 18) begin
      $display("FAIL hold_strobes got %0d strobes (last at %0d) required 1 at 18",
               strobes, valid_at);
    end else pass_cnt++;
    set_inputs(2'd0, ma, mb);
    @(posedge clk);
    @(negedge clk);
    M_valid = 1'b0; M_en = 1'b0;
    total_cnt++;
    if (W_mul_valid !== 1'b1 || W_mul_result !== ref_mul(2'd0, ma, mb)) begin
      $display("FAIL hold_next_mul got valid=%b result=%h required 1/%h",
               W_mul_valid, W_mul_result, ref_mul(2'd0, ma, mb));
    end else pass_cnt++;
    $display("HOLD MULXSS -> %h, then MUL -> %h", exp, W_mul_result);
  endtask

  // Reset in the middle of the hi*hi iterations.
  task automatic test_reset_mid();
    logic [31:0] last;
    last = W_mul_result;
    @(negedge clk);
    set_inputs(2'd1, $urandom, $urandom);
    M_valid = 1'b1; M_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    M_valid = 1'b0; M_en = 1'b0;
    repeat (8) @(negedge clk);
    total_cnt++;
    if (M_mul_stall !== 1'b1) begin
      $display("FAIL midreset_busy got stall=%b required 1", M_mul_stall);
    end else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++;
    if (M_mul_stall !== 1'b0 || W_mul_valid !== 1'b0 || W_mul_result !== 32'd0) begin
      $display("FAIL midreset_async got stall=%b valid=%b result=%h required 0/0/00000000 (prev %h)",
               M_mul_stall, W_mul_valid, W_mul_result, last);
    end else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      total_cnt++;
      if (W_mul_valid !== 1'b0 || M_mul_stall !== 1'b0) begin
        $display("FAIL midreset_quiet got valid=%b stall=%b required 0/0",
                 W_mul_valid, M_mul_stall);
      end else pass_cnt++;
    end
    do_mul(32'd3, 32'd5, "mul_after_reset");
    total_cnt++;
    if (W_mul_result !== 32'h0000000F) begin
      $display("FAIL mul_3x5 got %h required 0000000f", W_mul_result);
    end else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulx();
    test_back_to_back();
    test_hold_valid();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
